// File: rtl/dmem_write_buffer.sv
// Store write buffer in front of DataMemory: in-order FIFO drain, youngest-match load forwarding.
// Optional macro WB_COALESCE_EN: a store to the youngest entry's address overwrites that entry in place.
module dmem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       ST_VALID,
    input  logic [ADDR_W-1:0]          ST_ADDR,
    input  logic [DATA_W-1:0]          ST_DATA,
    output logic                       ST_READY,
    input  logic                       LD_EN,
    input  logic [ADDR_W-1:0]          LD_ADDR,
    output logic [DATA_W-1:0]          LD_DATA,
    output logic                       LD_HIT,
    output logic [ADDR_W-1:0]          MEM_A,
    output logic                       MEM_WE,
    output logic [DATA_W-1:0]          MEM_WD,
    input  logic [DATA_W-1:0]          MEM_RD,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       EMPTY
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  valid_nxt_s;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [PTR_W-1:0]  young_s;
    logic [CNT_W-1:0]  count_r;
    logic              empty_s;
    logic              full_s;
    logic              drain_s;
    logic              coal_hit_s;
    logic              enq_s;
    logic              coal_wr_s;
    logic [PTR_W-1:0]  fwd_idx_s;
    logic [PTR_W-1:0]  fwd_sel_s;
    logic              fwd_hit_s;
    logic              fwd_match_s;

    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign full_s  = (count_r == CNT_MAX);
    assign drain_s = RST_N && !LD_EN && !empty_s;
    assign young_s = tail_r - PTR_ONE;

`ifdef WB_COALESCE_EN
    // An entry being retired this edge cannot absorb a new store; it must allocate instead.
    assign coal_hit_s = !empty_s && valid_r[young_s] && (addr_r[young_s] == ST_ADDR)
                        && !(drain_s && (young_s == head_r));
`else
    assign coal_hit_s = 1'b0;
`endif

    assign ST_READY  = RST_N && (!full_s || coal_hit_s);
    assign enq_s     = ST_VALID && ST_READY && !coal_hit_s;
    assign coal_wr_s = ST_VALID && ST_READY && coal_hit_s;
    assign COUNT     = count_r;
    assign EMPTY     = empty_s;

    // Memory port arbitration: a load owns the port, otherwise the head entry drains.
    always_comb begin
        MEM_A  = {ADDR_W{1'b0}};
        MEM_WE = 1'b0;
        MEM_WD = {DATA_W{1'b0}};
        if (!RST_N) begin
            MEM_A  = {ADDR_W{1'b0}};
            MEM_WE = 1'b0;
            MEM_WD = {DATA_W{1'b0}};
        end else if (LD_EN) begin
            MEM_A  = LD_ADDR;
            MEM_WE = 1'b0;
            MEM_WD = {DATA_W{1'b0}};
        end else if (!empty_s) begin
            MEM_A  = addr_r[head_r];
            MEM_WE = 1'b1;
            MEM_WD = data_r[head_r];
        end else begin
            MEM_A  = {ADDR_W{1'b0}};
            MEM_WE = 1'b0;
            MEM_WD = {DATA_W{1'b0}};
        end
    end

    // Forwarding: scan oldest to youngest so the last match found is the youngest.
    always_comb begin
        fwd_idx_s   = head_r;
        fwd_sel_s   = head_r;
        fwd_hit_s   = 1'b0;
        fwd_match_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s   = head_r + PTR_W'(i);
            fwd_match_s = valid_r[fwd_idx_s] && (addr_r[fwd_idx_s] == LD_ADDR);
            fwd_sel_s   = fwd_match_s ? fwd_idx_s : fwd_sel_s;
            fwd_hit_s   = fwd_hit_s | fwd_match_s;
        end
        LD_HIT  = fwd_hit_s;
        LD_DATA = fwd_hit_s ? data_r[fwd_sel_s] : MEM_RD;
    end

    // Next valid mask: set the allocated slot, clear the retired one.
    always_comb begin
        valid_nxt_s = valid_r;
        if (enq_s) begin
            valid_nxt_s[tail_r] = 1'b1;
        end else begin
            valid_nxt_s[tail_r] = valid_r[tail_r];
        end
        if (drain_s) begin
            valid_nxt_s[head_r] = 1'b0;
        end else begin
            valid_nxt_s[head_r] = valid_nxt_s[head_r];
        end
    end

    // Pointers, occupancy and valid bits.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            valid_r <= {DEPTH{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            if (enq_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (drain_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({enq_s, drain_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload; gated by ST_READY, which is low during reset.
    always_ff @(posedge CLK) begin
        if (enq_s) begin
            addr_r[tail_r] <= ST_ADDR;
            data_r[tail_r] <= ST_DATA;
        end else if (coal_wr_s) begin
            data_r[young_s] <= ST_DATA;
        end
    end

endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Store write buffer between the datapath's load/store path and DataMemory (CLK, A[5:0], WE, WD[31:0], RD).
- Queues stores in a small FIFO and retires them in order, one per cycle, whenever the memory port is not needed by a load.
- Loads are forwarded from the youngest matching pending store; otherwise they read memory.
- Decouples store commit from the memory port and gives the port a single owner.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2
- ADDR_W, 6, word address width; matches DataMemory A
- DATA_W, 32, data width

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  reset, synchronous, active-low
- ST_VALID  input  1  store request from datapath
- ST_ADDR  input  ADDR_W  store word address
- ST_DATA  input  DATA_W  store data
- ST_READY  output  1  buffer can accept a store this cycle
- LD_EN  input  1  load access this cycle; owns memory port
- LD_ADDR  input  ADDR_W  load word address
- LD_DATA  output  DATA_W  load result (combinational)
- LD_HIT  output  1  LD_DATA was forwarded from the buffer
- MEM_A  output  ADDR_W  to DataMemory A
- MEM_WE  output  1  to DataMemory WE
- MEM_WD  output  DATA_W  to DataMemory WD
- MEM_RD  input  DATA_W  from DataMemory RD (combinational read)
- COUNT  output  $clog2(DEPTH+1)  occupied entries
- EMPTY  output  1  COUNT==0

Behaviour:
- Storage: circular FIFO with head and tail pointers.
  - Pointers wrap modulo DEPTH.
  - Full/empty is derived from COUNT, not from pointer equality.
- Reset: while RST_N=0, the following are forced combinationally:
  - ST_READY=0, MEM_WE=0, MEM_A=0, MEM_WD=0.
  - On the rising edge with RST_N=0: head=0, tail=0, COUNT=0, all entry valid bits cleared.
  - Pending stores are discarded and never written to memory, including on reset mid-drain.
- Enqueue:
  - ST_READY = RST_N && (COUNT<DEPTH).
  - On a rising edge with ST_VALID && ST_READY: the entry at tail is written and tail advances.
  - ST_VALID while not ready: the store is not taken; the datapath holds it (stall).
- Port arbitration, combinational, each cycle:
  - LD_EN=1: MEM_A=LD_ADDR, MEM_WE=0, MEM_WD=0. The load owns the port and no drain occurs.
  - LD_EN=0 and !EMPTY: MEM_A=head.addr, MEM_WE=1, MEM_WD=head.data. The head is retired at the rising edge and head advances.
  - Otherwise: MEM_A=0, MEM_WE=0, MEM_WD=0.
- Drain latency: a store accepted at edge N is presented to memory in cycle N+1 at the earliest, if it is at the head and LD_EN=0. It is written at edge N+1.
- Ordering: strict FIFO order; stores to the same address retire oldest first.
- Forwarding:
  - LD_DATA = data of the youngest valid entry with addr==LD_ADDR, and LD_HIT=1.
  - Otherwise LD_DATA=MEM_RD and LD_HIT=0.
  - A store being enqueued in the same cycle is not visible until after the edge.
- Simultaneous enqueue and drain in one edge: COUNT unchanged, both pointers advance.
- Full with drain in the same cycle: ST_READY stays 0 (no pass-through); the slot becomes available next cycle.
- COUNT never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: WB_COALESCE_EN.
- When defined, a store whose address equals the youngest entry's address (tail-1) overwrites that entry's data instead of allocating a new one.
  - Condition: that entry is not simultaneously being retired (i.e. not head with drain active).
  - The overwrite occurs at the rising edge.
  - COUNT and the pointers do not change.
  - ST_READY=1 for such a store even when COUNT==DEPTH.
- When not defined, every accepted store allocates a new entry; behaviour is exactly as above.

Test Plan:
- Reset: RST_N=0 for 2 cycles with ST_VALID=1 -> ST_READY=0, MEM_WE=0; after release COUNT=0, EMPTY=1, ST_READY=1.
- Single store: ST_ADDR=5, ST_DATA=0xDEADBEEF, LD_EN=0 -> next cycle MEM_WE=1, MEM_A=5, MEM_WD=0xDEADBEEF; after that edge EMPTY=1 and memory word 5 reads 0xDEADBEEF.
- Fill and stall: LD_EN=1 held, stores to addr 1,2,3,4 -> COUNT=4, ST_READY=0, 5th store (addr 9) held. Release LD_EN -> MEM_A sequence 1,2,3,4, then 9, one per cycle.
- Forwarding: LD_EN=1, stores addr 7 data 0x11 then addr 7 data 0x22.
  - LD_ADDR=7 -> LD_DATA=0x22, LD_HIT=1.
  - LD_ADDR=8 -> LD_DATA=MEM_RD, LD_HIT=0.
  - With WB_COALESCE_EN defined: COUNT=1 instead of 2.
- Concurrent: COUNT=2, LD_EN=0, ST_VALID=1 addr 3 -> after edge COUNT=2, oldest entry written to memory.
- Reset mid-operation: COUNT=3, LD_EN=1, pulse RST_N=0 for one edge -> COUNT=0, no MEM_WE=1 for any of the 3 entries afterward, memory contents unchanged.
